sseg_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 8-digit seven-segment display driver.
- Samples the scanned anode/segment bus (active-low anodes, active-high segments), recovers the digit value shown on each of the 8 positions, and publishes a complete frame once per scan.
- Used by the game logic to read back the countdown display, and by benches as a display monitor.

---
 rtl/sseg_scan_decoder_pkg.sv | 33 +++
 rtl/sseg_pattern_decode.sv | 34 +++
 rtl/sseg_scan_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_scan_decoder_pkg.sv
//============================================================================
// sseg_scan_decoder_pkg: segment patterns, digit codes, FSM encoding. Rev 1.0
//============================================================================
`default_nettype none

package sseg_scan_decoder_pkg;

  // Patterns are {g,f,e,d,c,b,a}, active-high; shared with the display driver.
  localparam logic [6:0] c_SEG_0     = 7'b0111111;
  localparam logic [6:0] c_SEG_1     = 7'b0000110;
  localparam logic [6:0] c_SEG_2     = 7'b1011011;
  localparam logic [6:0] c_SEG_3     = 7'b1001111;
  localparam logic [6:0] c_SEG_4     = 7'b1100110;
  localparam logic [6:0] c_SEG_5     = 7'b1101101;
  localparam logic [6:0] c_SEG_6     = 7'b1111101;
  localparam logic [6:0] c_SEG_7     = 7'b0000111;
  localparam logic [6:0] c_SEG_8     = 7'b1111111;
  localparam logic [6:0] c_SEG_9     = 7'b1101111;
  localparam logic [6:0] c_SEG_DASH  = 7'b1000000;
  localparam logic [6:0] c_SEG_BLANK = 7'b0000000;

  localparam logic [3:0] c_DIG_DASH    = 4'hA;
  localparam logic [3:0] c_DIG_BLANK   = 4'hB;
  localparam logic [3:0] c_DIG_INVALID = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sseg_pattern_decode.sv
//============================================================================
// sseg_pattern_decode: 7-bit segment pattern to 4-bit digit code. Rev 1.0
//============================================================================
`default_nettype none

module sseg_pattern_decode
  import sseg_scan_decoder_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_code
);

  always_comb begin
    o_code = c_DIG_INVALID;
    case (i_pattern)
      c_SEG_0:     o_code = 4'd0;
      c_SEG_1:     o_code = 4'd1;
      c_SEG_2:     o_code = 4'd2;
      c_SEG_3:     o_code = 4'd3;
      c_SEG_4:     o_code = 4'd4;
      c_SEG_5:     o_code = 4'd5;
      c_SEG_6:     o_code = 4'd6;
      c_SEG_7:     o_code = 4'd7;
      c_SEG_8:     o_code = 4'd8;
      c_SEG_9:     o_code = 4'd9;
      c_SEG_DASH:  o_code = c_DIG_DASH;
      c_SEG_BLANK: o_code = c_DIG_BLANK;
      default:     o_code = c_DIG_INVALID;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sseg_scan_decoder.sv
//============================================================================
// sseg_scan_decoder: samples a scanned 8-digit 7-seg bus into frames. Rev 1.0
//============================================================================
`default_nettype none

module sseg_scan_decoder
  import sseg_scan_decoder_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  output logic [31:0] digits,
  output logic [7:0]  dp_mask,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        link_active
);

  localparam int c_TW = $clog2(TIMEOUT);

  logic [6:0]  w_seg;
  logic [15:0] w_sample;
  logic [3:0]  w_code;
  logic [7:0]  w_an_low;
  logic [7:0]  w_prev_an_low;
  logic        w_blank;
  logic        w_valid;
  logic        w_glitch;
  logic        w_prev_glitch;
  logic [2:0]  w_index;
  logic [7:0]  w_bit;
  logic [2:0]  w_settle_next;
  logic        w_capture;
  logic        w_timeout;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_mask;
  logic [7:0]  w_mask_next;
  logic [2:0]  r_expect;
  logic [2:0]  w_expect_next;
  logic        w_store;
  logic        w_publish;
  logic        w_error;

  logic [15:0]     r_prev;
  logic [2:0]      r_settle;
  logic [c_TW-1:0] r_tmo;
  logic            r_link;
  logic [31:0]     r_shadow;
  logic [7:0]      r_shadow_dp;
  logic [31:0]     r_digits;
  logic [7:0]      r_dp_mask;
  logic            r_frame_valid;
  logic            r_frame_error;

  assign w_seg    = {g, f, e, d, c, b, a};
  assign w_sample = {an, w_seg, dp};

  sseg_pattern_decode u_decode (
    .i_pattern (w_seg),
    .o_code    (w_code)
  );

  assign w_an_low      = ~an;
  assign w_blank       = (an == 8'hFF);
  assign w_valid       = !w_blank && ((w_an_low & (w_an_low - 8'd1)) == 8'd0);
  assign w_glitch      = !w_blank && !w_valid;
  assign w_prev_an_low = ~r_prev[15:8];
  // A glitch held over several cycles raises a single error pulse.
  assign w_prev_glitch = (r_prev[15:8] != 8'hFF) &&
                         ((w_prev_an_low & (w_prev_an_low - 8'd1)) != 8'd0);

  always_comb begin
    w_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) w_index = 3'(i);
    end
  end

  assign w_bit = 8'd1 << w_index;

  // Saturating at 7 keeps the capture to a single cycle per dwell.
  assign w_settle_next = (w_valid && (w_sample == r_prev))
                       ? ((r_settle == 3'd7) ? 3'd7 : r_settle + 3'd1)
                       : 3'd0;
  assign w_capture = w_valid && (w_settle_next == 3'(SETTLE - 1));
  assign w_timeout = r_link && (r_tmo == c_TW'(TIMEOUT - 1)) && !w_capture;

  always_comb begin
    w_state_next  = r_state;
    w_mask_next   = r_mask;
    w_expect_next = r_expect;
    w_store       = 1'b0;
    w_publish     = 1'b0;
    w_error       = 1'b0;
    if (w_glitch) begin
      w_state_next = ST_IDLE;
      w_mask_next  = 8'd0;
      w_error      = !w_prev_glitch;
    end else if (w_timeout) begin
      w_state_next = ST_IDLE;
      w_mask_next  = 8'd0;
    end else if (w_capture) begin
      case (r_state)
        ST_IDLE: begin
          if (w_index == 3'd0) begin
            w_store       = 1'b1;
            w_mask_next   = 8'd1;
            w_expect_next = 3'd1;
            w_state_next  = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_index == r_expect) begin
            w_store = 1'b1;
            if ((r_mask | w_bit) == 8'hFF) begin
              w_publish    = 1'b1;
              w_mask_next  = 8'd0;
              w_state_next = ST_IDLE;
            end else begin
              w_mask_next   = r_mask | w_bit;
              w_expect_next = r_expect + 3'd1;
            end
          end else if (w_index == 3'd0) begin
            w_store       = 1'b1;
            w_mask_next   = 8'd1;
            w_expect_next = 3'd1;
            w_error       = 1'b1;
          end else begin
            w_error      = 1'b1;
            w_mask_next  = 8'd0;
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_mask_next  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_mask   <= 8'd0;
      r_expect <= 3'd0;
    end else begin
      r_state  <= w_state_next;
      r_mask   <= w_mask_next;
      r_expect <= w_expect_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev        <= {8'hFF, 8'h00};
      r_settle      <= 3'd0;
      r_tmo         <= '0;
      r_link        <= 1'b0;
      r_shadow      <= 32'd0;
      r_shadow_dp   <= 8'd0;
      r_digits      <= 32'd0;
      r_dp_mask     <= 8'd0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_prev        <= w_sample;
      r_settle      <= w_settle_next;
      r_frame_valid <= w_publish;
      r_frame_error <= w_error;
      if (w_capture) begin
        r_tmo  <= '0;
        r_link <= 1'b1;
      end else begin
        if (r_tmo != c_TW'(TIMEOUT - 1)) r_tmo <= r_tmo + 1'b1;
        if (w_timeout) r_link <= 1'b0;
      end
      if (w_store) begin
        r_shadow[4*w_index +: 4] <= w_code;
        r_shadow_dp[w_index]     <= dp;
      end
      // Digit 7 is merged straight from the bus so publish costs one cycle.
      if (w_publish) begin
        r_digits  <= {w_code, r_shadow[27:0]};
        r_dp_mask <= {dp, r_shadow_dp[6:0]};
      end
    end
  end

  assign digits      = r_digits;
  assign dp_mask     = r_dp_mask;
  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign link_active = r_link;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
//============================================================================
// tb_sseg_scan_decoder: directed self-checking bench for the scan decoder.
//============================================================================
`default_nettype none

module tb_sseg_scan_decoder;

  localparam int TMO = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  an = 8'hFF;
  logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic        e = 1'b0, f = 1'b0, g = 1'b0, dp = 1'b0;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic        frame_valid;
  logic        frame_error;
  logic        link_active;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fv_cnt  = 0;
  int fe_cnt  = 0;
  int last_fv = -1;
  int last_fe = -1;

  sseg_scan_decoder #(.SETTLE(2), .TIMEOUT(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .an          (an),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .e           (e),
    .f           (f),
    .g           (g),
    .dp          (dp),
    .digits      (digits),
    .dp_mask     (dp_mask),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .link_active (link_active)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (frame_valid) begin fv_cnt <= fv_cnt + 1; last_fv <= cyc; end
    if (frame_error) begin fe_cnt <= fe_cnt + 1; last_fe <= cyc; end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: seg_of = 7'b0111111;
      4'd1: seg_of = 7'b0000110;
      4'd2: seg_of = 7'b1011011;
      4'd3: seg_of = 7'b1001111;
      4'd4: seg_of = 7'b1100110;
      4'd5: seg_of = 7'b1101101;
      4'd6: seg_of = 7'b1111101;
      4'd7: seg_of = 7'b0000111;
      4'd8: seg_of = 7'b1111111;
      4'd9: seg_of = 7'b1101111;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  function automatic logic [55:0] segs_of(input logic [31:0] w);
    logic [55:0] s;
    for (int i = 0; i < 8; i++) s[7*i +: 7] = seg_of(w[4*i +: 4]);
    return s;
  endfunction

  task automatic drive(input int idx, input logic [6:0] s, input logic p);
    an = ~(8'd1 << idx);
    {g, f, e, d, c, b, a} = s;
    dp = p;
  endtask

  task automatic show(input int idx, input logic [6:0] s, input logic p, input int n);
    repeat (n) begin
      @(negedge clock);
      drive(idx, s, p);
    end
  endtask

  // c7 = cycle count at the negedge where digit 7 first appears.
  task automatic scan_raw(input logic [55:0] s, input logic [7:0] dpm,
                          input int dwell, output int c7);
    c7 = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < dwell; j++) begin
        @(negedge clock);
        if (i == 7 && j == 0) c7 = cyc;
        drive(i, s[7*i +: 7], dpm[i]);
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_tests++; if (digits !== 32'd0) begin n_fail++; $display("FAIL reset_digits: got %h want 00000000", digits); end
    n_tests++; if (dp_mask !== 8'd0) begin n_fail++; $display("FAIL reset_dp_mask: got %h want 00", dp_mask); end
    n_tests++; if ({frame_valid, frame_error} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {frame_valid, frame_error}); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_tests++; if (link_active !== 1'b0) begin n_fail++; $display("FAIL reset_link: got %b want 0", link_active); end
  endtask

  task automatic test_basic_scan;
    int f0, e0, c7;
    f0 = fv_cnt; e0 = fe_cnt;
    scan_raw(segs_of(32'h0180_0000), 8'h10, 8, c7);
    n_tests++; if (fv_cnt - f0 !== 1) begin n_fail++; $display("FAIL basic_fv_count: got %0d want 1", fv_cnt - f0); end
    n_tests++; if (last_fv !== c7 + 2) begin n_fail++; $display("FAIL basic_latency: got cycle %0d want %0d", last_fv, c7 + 2); end
    n_tests++; if (digits !== 32'h0180_0000) begin n_fail++; $display("FAIL basic_digits: got %h want 01800000", digits); end
    n_tests++; if (dp_mask !== 8'h10) begin n_fail++; $display("FAIL basic_dp_mask: got %h want 10", dp_mask); end
    n_tests++; if (link_active !== 1'b1) begin n_fail++; $display("FAIL basic_link: got %b want 1", link_active); end
    scan_raw(segs_of(32'h0180_0000), 8'h10, 8, c7);
    n_tests++; if (fv_cnt - f0 !== 2) begin n_fail++; $display("FAIL back_to_back_fv: got %0d want 2", fv_cnt - f0); end
    n_tests++; if (last_fv !== c7 + 2) begin n_fail++; $display("FAIL back_to_back_latency: got %0d want %0d", last_fv, c7 + 2); end
    n_tests++; if (fe_cnt !== e0) begin n_fail++; $display("FAIL basic_no_error: got %0d errors want 0", fe_cnt - e0); end
  endtask

  task automatic test_fast_dwell_timeout;
    int f0, e0, c1, target, guard, n;
    f0 = fv_cnt; e0 = fe_cnt;
    show(0, seg_of(4'd3), 1'b0, 2);
    c1 = cyc;
    target = c1 + TMO;
    guard = 0; n = 0;
    while (cyc != target && guard < 3000) begin
      @(negedge clock);
      drive((n % 7) + 1, seg_of(4'd5), 1'b0);
      n++; guard++;
    end
    n_tests++; if (guard >= 3000) begin n_fail++; $display("FAIL timeout_wait: cycle budget expired at %0d want %0d", cyc, target); end
    n_tests++; if (link_active !== 1'b1) begin n_fail++; $display("FAIL timeout_link_before: got %b want 1", link_active); end
    @(negedge clock);
    drive((n % 7) + 1, seg_of(4'd5), 1'b0);
    n_tests++; if (link_active !== 1'b0) begin n_fail++; $display("FAIL timeout_link_after: got %b want 0", link_active); end
    n_tests++; if (fv_cnt !== f0) begin n_fail++; $display("FAIL fast_dwell_fv: got %0d pulses want 0", fv_cnt - f0); end
    n_tests++; if (fe_cnt !== e0) begin n_fail++; $display("FAIL fast_dwell_fe: got %0d pulses want 0", fe_cnt - e0); end
  endtask

  task automatic test_skip_index;
    int f0, e0, c4;
    f0 = fv_cnt; e0 = fe_cnt;
    for (int i = 0; i < 3; i++) show(i, seg_of(4'd5), 1'b0, 4);
    @(negedge clock);
    c4 = cyc;
    drive(4, seg_of(4'd5), 1'b0);
    show(4, seg_of(4'd5), 1'b0, 3);
    n_tests++; if (fe_cnt - e0 !== 1) begin n_fail++; $display("FAIL skip_fe_count: got %0d want 1", fe_cnt - e0); end
    n_tests++; if (last_fe !== c4 + 2) begin n_fail++; $display("FAIL skip_fe_time: got %0d want %0d", last_fe, c4 + 2); end
    n_tests++; if (fv_cnt !== f0) begin n_fail++; $display("FAIL skip_fv: got %0d pulses want 0", fv_cnt - f0); end
    n_tests++; if (digits !== 32'h0180_0000) begin n_fail++; $display("FAIL skip_digits_hold: got %h want 01800000", digits); end
  endtask

  task automatic test_glitch;
    int f0, e0, c7;
    f0 = fv_cnt; e0 = fe_cnt;
    for (int i = 0; i < 4; i++) show(i, seg_of(4'd9), 1'b0, 4);
    repeat (3) begin
      @(negedge clock);
      an = 8'b1111_0011;
    end
    @(negedge clock);
    n_tests++; if (fe_cnt - e0 !== 1) begin n_fail++; $display("FAIL glitch_fe_count: got %0d want 1", fe_cnt - e0); end
    scan_raw(segs_of(32'h1234_5678), 8'h81, 4, c7);
    n_tests++; if (fv_cnt - f0 !== 1) begin n_fail++; $display("FAIL glitch_recover_fv: got %0d want 1", fv_cnt - f0); end
    n_tests++; if (digits !== 32'h1234_5678) begin n_fail++; $display("FAIL glitch_recover_digits: got %h want 12345678", digits); end
    n_tests++; if (dp_mask !== 8'h81) begin n_fail++; $display("FAIL glitch_recover_dp: got %h want 81", dp_mask); end
  endtask

  task automatic test_dash_blank;
    logic [55:0] s;
    int c7;
    for (int i = 0; i < 8; i++) s[7*i +: 7] = 7'b1000000;
    scan_raw(s, 8'h00, 3, c7);
    n_tests++; if (digits !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL dash_digits: got %h want AAAAAAAA", digits); end
    s[14 +: 7] = 7'b0000000;
    scan_raw(s, 8'h00, 3, c7);
    n_tests++; if (digits !== 32'hAAAA_ABAA) begin n_fail++; $display("FAIL blank_digits: got %h want AAAAABAA", digits); end
    s[14 +: 7] = 7'b1000000;
    s[0 +: 7]  = 7'b0101010;
    scan_raw(s, 8'h24, 3, c7);
    n_tests++; if (digits !== 32'hAAAA_AAAF) begin n_fail++; $display("FAIL invalid_digits: got %h want AAAAAAAF", digits); end
    n_tests++; if (dp_mask !== 8'h24) begin n_fail++; $display("FAIL invalid_dp: got %h want 24", dp_mask); end
  endtask

  task automatic test_reset_mid;
    int f0, c7;
    for (int i = 0; i < 5; i++) show(i, seg_of(4'd3), 1'b1, 4);
    show(5, seg_of(4'd3), 1'b1, 1);
    #2 reset = 1'b1;
    #1;
    n_tests++; if (digits !== 32'd0) begin n_fail++; $display("FAIL async_reset_digits: got %h want 00000000", digits); end
    n_tests++; if (dp_mask !== 8'd0) begin n_fail++; $display("FAIL async_reset_dp: got %h want 00", dp_mask); end
    n_tests++; if (link_active !== 1'b0) begin n_fail++; $display("FAIL async_reset_link: got %b want 0", link_active); end
    @(negedge clock);
    reset = 1'b0;
    f0 = fv_cnt;
    scan_raw(segs_of(32'h8765_4321), 8'h0F, 4, c7);
    n_tests++; if (fv_cnt - f0 !== 1) begin n_fail++; $display("FAIL post_reset_fv: got %0d want 1", fv_cnt - f0); end
    n_tests++; if (digits !== 32'h8765_4321) begin n_fail++; $display("FAIL post_reset_digits: got %h want 87654321", digits); end
    n_tests++; if (dp_mask !== 8'h0F) begin n_fail++; $display("FAIL post_reset_dp: got %h want 0F", dp_mask); end
    n_tests++; if (link_active !== 1'b1) begin n_fail++; $display("FAIL post_reset_link: got %b want 1", link_active); end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_fast_dwell_timeout();
    test_skip_index();
    test_glitch();
    test_dash_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule

`default_nettype wire
